// File: rtl/lights_sequencer.sv
// Start-lights sequencer: lights NUM_LIGHTS lamps one per timed step, holds, then goes dark.
// Define LIGHTS_SEQUENCER_RANDOM_HOLD_EN to add a random LFSR offset to the hold delay.
module lights_sequencer #(
    parameter int BIT_SZ     = 14,
    parameter int NUM_LIGHTS = 10,
    parameter int STEP_N     = 500,
    parameter int HOLD_N     = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  time_out,
    output logic                  trigger,
    output logic [BIT_SZ-1:0]     N_out,
    output logic [NUM_LIGHTS-1:0] ledr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_e;

    // The delay timer treats a count of zero as undefined, so it is bumped to one.
    function automatic logic [BIT_SZ-1:0] nonzero(input logic [BIT_SZ-1:0] v);
        return (v == '0) ? BIT_SZ'(1) : v;
    endfunction

    localparam logic [BIT_SZ-1:0] STEP_V   = nonzero(BIT_SZ'(STEP_N));
    localparam int                IDX_W    = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LIGHTS - 1);

    state_e                  state_q, state_d;
    logic                    gap_q, gap_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    hold_q, hold_d;
    logic                    arm_q, arm_d;
    logic                    trig_q, trig_d;
    logic [BIT_SZ-1:0]       nout_q, nout_d;
    logic [NUM_LIGHTS-1:0]   ledr_q, ledr_d;
    logic                    done_q, done_d;
    logic [BIT_SZ-1:0]       hold_val;

`ifdef LIGHTS_SEQUENCER_RANDOM_HOLD_EN
    logic [13:0]   lfsr_q, lfsr_d;
    logic [BIT_SZ:0] hold_sum;

    // x^14 + x^13 + x^12 + x^2 + 1, shifting towards the MSB.
    always_comb begin
        lfsr_d   = {lfsr_q[12:0], lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[1]};
        hold_sum = {1'b0, BIT_SZ'(HOLD_N)} + (BIT_SZ + 1)'(lfsr_q[9:0]);
        hold_val = hold_sum[BIT_SZ] ? '1 : nonzero(hold_sum[BIT_SZ-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 14'h0001;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign hold_val = nonzero(BIT_SZ'(HOLD_N));
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        arm_d   = 1'b1;
        trig_d  = trig_q;
        nout_d  = nout_q;
        ledr_d  = ledr_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // arm_q keeps the first request off the first edge after reset release.
                if (start && arm_q) begin
                    nout_d  = STEP_V;
                    trig_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (time_out) begin
                    trig_d  = 1'b0;
                    gap_d   = 1'b0;
                    state_d = GAP;
                    if (hold_q) begin
                        ledr_d = '0;
                        done_d = 1'b1;
                    end else begin
                        ledr_d = ledr_q | (NUM_LIGHTS'(1) << idx_q);
                    end
                end
            end
            GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (hold_q) begin
                    hold_d  = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + IDX_W'(1);
                    nout_d  = STEP_V;
                    trig_d  = 1'b1;
                    state_d = REQ;
                end else begin
                    hold_d  = 1'b1;
                    nout_d  = hold_val;
                    trig_d  = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= 1'b0;
            idx_q   <= '0;
            hold_q  <= 1'b0;
            arm_q   <= 1'b0;
            trig_q  <= 1'b0;
            nout_q  <= STEP_V;
            ledr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            arm_q   <= arm_d;
            trig_q  <= trig_d;
            nout_q  <= nout_d;
            ledr_q  <= ledr_d;
            done_q  <= done_d;
        end
    end

    assign trigger = trig_q;
    assign N_out   = nout_q;
    assign ledr    = ledr_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule
